// File: rtl/rfa_pkg.sv
// rfa_pkg: shared requester indices, select width and arbiter states for the VGPR write-back arbiter.
package rfa_pkg;
  localparam int SIMD0_IDX = 0;
  localparam int SIMD1_IDX = 1;
  localparam int SIMD2_IDX = 2;
  localparam int SIMD3_IDX = 3;
  localparam int SIMF0_IDX = 4;
  localparam int SIMF1_IDX = 5;
  localparam int SIMF2_IDX = 6;
  localparam int SIMF3_IDX = 7;
  localparam int LSU_IDX   = 8;
  localparam int SEL_W     = 16;
  typedef enum logic {S_ARB, S_LOCK} state_e;
endpackage

// File: rtl/rfa_wb_arbiter_rr_pick8.sv
// rr_pick8: combinational round-robin find-first over 8 requests, scanning upward from ptr with wrap.
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       vld,
  output logic [2:0] idx
);
  logic [15:0] dbl;
  logic [7:0]  rot;
  logic [2:0]  k;
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[7:0];
  always_comb begin
    k = '0;
    for (int i = 7; i >= 0; i--) if (rot[i]) k = 3'(i);
  end
  assign vld = |req;
  assign idx = ptr + k;
endmodule

// File: rtl/rfa_wb_arbiter.sv
// rfa_wb_arbiter: VGPR write-back arbiter (starved ALUs > LSU > round-robin ALUs, 2-beat LSU lock).
// Profiling counters are built only when RFA_PROFILE_EN is defined; otherwise they read 0.
module rfa_wb_arbiter
  import rfa_pkg::*;
#(
  parameter int NUM_REQ      = 9,
  parameter int LSU_IDX      = 8,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4,
  parameter int PROF_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] fu_req,
  input  logic               lsu_multi,
  input  logic               wb_stall,
  output logic [SEL_W-1:0]   select_fu,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] starve_flag,
  output logic [PROF_W-1:0]  prof_grant_cnt,
  output logic [PROF_W-1:0]  prof_conflict_cnt
);
  state_e                        state_q, state_d;
  logic [SEL_W-1:0]              select_fu_q, select_fu_d;
  logic [2:0]                    rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0]            starve_q, starve_d, req_m;
  logic                          s_vld, a_vld;
  logic [2:0]                    s_idx, a_idx;
  // last cycle's winner sits out this decision
  assign req_m = fu_req & ~select_fu_q[NUM_REQ-1:0];
  rr_pick8 u_starve (.req(starve_q[7:0] & req_m[7:0]), .ptr(rr_ptr_q), .vld(s_vld), .idx(s_idx));
  rr_pick8 u_alu    (.req(req_m[7:0]), .ptr(rr_ptr_q), .vld(a_vld), .idx(a_idx));
  always_comb begin
    select_fu_d = '0;
    state_d     = S_ARB;
    rr_ptr_d    = rr_ptr_q;
    if (state_q == S_LOCK) select_fu_d = SEL_W'(1) << LSU_IDX;
    else if (!wb_stall) begin
      if (s_vld) begin
        select_fu_d = SEL_W'(1) << s_idx;
        rr_ptr_d    = s_idx + 3'd1;
      end else if (req_m[LSU_IDX]) begin
        select_fu_d = SEL_W'(1) << LSU_IDX;
        state_d     = lsu_multi ? S_LOCK : S_ARB;
      end else if (a_vld) begin
        select_fu_d = SEL_W'(1) << a_idx;
        rr_ptr_d    = a_idx + 3'd1;
      end
    end
  end
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i]    = (!fu_req[i] || select_fu_d[i]) ? '0 :
                    (cnt_q[i] == CNT_W'(STARVE_LIMIT)) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
      starve_d[i] = cnt_d[i] == CNT_W'(STARVE_LIMIT);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_ARB;
      select_fu_q <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      select_fu_q <= select_fu_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end
  assign select_fu   = select_fu_q;
  assign grant_valid = |select_fu_q;
  assign starve_flag = starve_q;
`ifdef RFA_PROFILE_EN
  logic [PROF_W-1:0] grant_cnt_q, grant_cnt_d, conflict_cnt_q, conflict_cnt_d;
  always_comb begin
    grant_cnt_d    = grant_cnt_q + PROF_W'(|select_fu_d);
    conflict_cnt_d = conflict_cnt_q + PROF_W'($countones(req_m) > 1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt_q    <= grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end
  assign prof_grant_cnt    = grant_cnt_q;
  assign prof_conflict_cnt = conflict_cnt_q;
`else
  assign prof_grant_cnt    = '0;
  assign prof_conflict_cnt = '0;
`endif
endmodule
